// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, reset vector and IF/ID payload type for the fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned ARCH_WIDTH = 32;
  localparam int unsigned IM_WIDTH   = 32;

  localparam logic [ARCH_WIDTH-1:0] RESET_PC  = 32'h0000_3000;
  localparam logic [IM_WIDTH-1:0]   INSTR_NOP = 32'h6000_0000;  // ori 0,0,0
  localparam logic [ARCH_WIDTH-1:0] PC_STEP   = 32'd4;

  // Instructions are word aligned; the low two address bits are always zero.
  localparam logic [ARCH_WIDTH-1:0] PC_ALIGN_MASK = ~ARCH_WIDTH'(3);

  // One IF/ID entry: the instruction word and the address it was fetched from.
  typedef struct packed {
    logic [ARCH_WIDTH-1:0] pc;
    logic [IM_WIDTH-1:0]   instr;
  } if_entry_t;

  // Force a redirect target onto a word boundary.
  function automatic logic [ARCH_WIDTH-1:0] align_pc(input logic [ARCH_WIDTH-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, execute redirect and the IF/ID handshake.
// Instruction words keep the [0:31] numbering of the ISA; they are passed through untouched.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic [ARCH_WIDTH-1:0] im_addr;
  logic [IM_WIDTH-1:0]   im_dout;
  logic                  redirect_valid;
  logic [ARCH_WIDTH-1:0] redirect_pc;
  logic                  id_valid;
  logic                  id_ready;
  logic [IM_WIDTH-1:0]   id_instr;
  logic [ARCH_WIDTH-1:0] id_pc;

  // Fetch stage side.
  modport master (
    output im_addr, id_valid, id_instr, id_pc,
    input  im_dout, redirect_valid, redirect_pc, id_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  im_addr, id_valid, id_instr, id_pc,
    output im_dout, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Two-entry IF/ID buffer with flush; only built when IF_FIFO_EN is defined.
// Entries are kept as a head/tail pair so the head (the decode-facing entry) is always
// a plain register rather than a read mux.
`ifdef IF_FIFO_EN
module if_fetch_fifo
  import if_fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  if_entry_t din,
  output if_entry_t head,
  output logic      full,
  output logic      empty
);

  logic [1:0] count_q;
  if_entry_t  head_q;
  if_entry_t  tail_q;

  assign head  = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  // Storage and occupancy; flush discards everything, push is ignored when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push && !full && pop && !empty) begin
      if (count_q == 2'd1) begin
        head_q <= din;
      end else begin
        head_q <= tail_q;
        tail_q <= din;
      end
    end else if (push && !full) begin
      if (empty) head_q <= din;
      else       tail_q <= din;
      count_q <= 2'(count_q + 2'd1);
    end else if (pop && !empty) begin
      head_q  <= tail_q;
      count_q <= 2'(count_q - 2'd1);
    end
  end

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the zero-latency instruction memory and
// presents {pc, instr} to decode over valid/ready. Execute redirects win over everything.
// Build option IF_FIFO_EN: a 2-entry buffer decouples pc advance from id_ready.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  if_fetch_stage_if.master bus
);

  logic [ARCH_WIDTH-1:0] pc_q;
  logic                  fire_c;
  if_entry_t             fetch_entry_c;

  assign bus.im_addr   = pc_q;
  assign fetch_entry_c = '{pc: pc_q, instr: bus.im_dout};

`ifdef IF_FIFO_EN
  logic      fifo_full;
  logic      fifo_empty;
  if_entry_t fifo_head;

  // Fetch only looks at the registered full flag, never at id_ready.
  assign fire_c = !fifo_full && !bus.redirect_valid;

  if_fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (fire_c),
    .pop   (bus.id_valid && bus.id_ready),
    .din   (fetch_entry_c),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.id_valid = !fifo_empty;
  assign bus.id_pc    = fifo_head.pc;
  assign bus.id_instr = fifo_head.instr;
`else
  logic      valid_q;
  if_entry_t entry_q;

  // Slot can be refilled when empty or drained by decode this same cycle.
  assign fire_c = (!valid_q || bus.id_ready) && !bus.redirect_valid;

  // Single IF/ID register; a redirect squashes it, otherwise it holds until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (bus.redirect_valid) begin
      valid_q <= 1'b0;
    end else if (fire_c) begin
      valid_q <= 1'b1;
      entry_q <= fetch_entry_c;
    end
  end

  assign bus.id_valid = valid_q;
  assign bus.id_pc    = entry_q.pc;
  assign bus.id_instr = entry_q.instr;
`endif

  // Program counter: redirect target, sequential step (wraps modulo 2**ARCH_WIDTH), or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_q <= align_pc(bus.redirect_pc);
    end else if (fire_c) begin
      pc_q <= ARCH_WIDTH'(pc_q + PC_STEP);
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed reset/stream/stall/redirect/wrap/async
// reset scenarios followed by random ready/redirect traffic against an in-order PC model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_stage_if bus();

  if_fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.im_dout = mem_word(bus.im_addr);

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample pre-edge handshake, clock, then check against the stream model.
  // Model: decode sees an unbroken sequence exp_pc, exp_pc+4, ... restarted by redirects.
  task automatic cycle();
    logic        pv, pr, prv;
    logic [31:0] ppc, pin, prp;
    pv  = bus.id_valid;
    pr  = bus.id_ready;
    prv = bus.redirect_valid;
    prp = bus.redirect_pc;
    ppc = bus.id_pc;
    pin = bus.id_instr;
    @(posedge clk);
    #1;
    if (pv && pr) exp_pc = exp_pc + 32'd4;
    if (prv) begin
      exp_pc = {prp[31:2], 2'b00};
      check_eq("redir_valid", 32'(bus.id_valid), 32'd0);
      check_eq("redir_addr", bus.im_addr, exp_pc);
    end else begin
      check_eq("valid_kept", 32'(bus.id_valid), 32'd1);
      if (pv && !pr) begin
        check_eq("hold_pc", bus.id_pc, ppc);
        check_eq("hold_instr", bus.id_instr, pin);
      end
      if (bus.id_valid) begin
        check_eq("seq_pc", bus.id_pc, exp_pc);
        check_eq("seq_instr", bus.id_instr, mem_word(exp_pc));
      end
    end
  endtask

  // Hold reset for three clocks, check reset state, release.
  task automatic do_reset();
    rst_n              = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr", bus.im_addr, 32'h0000_3000);
    check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_pc", bus.id_pc, 32'd0);
    check_eq("rst_instr", bus.id_instr, 32'd0);
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
  endtask

  initial begin
    // 1. reset and first fetch
    do_reset();
    bus.id_ready = 1'b1;
    cycle();
    check_eq("first_pc", bus.id_pc, 32'h0000_3000);
    check_eq("first_instr", bus.id_instr, mem_word(32'h0000_3000));

    // 2. streaming, one per cycle
    for (int k = 0; k < 8; k++) begin
      check_eq("stream_pc", bus.id_pc, 32'h0000_3000 + 32'(4 * k));
      cycle();
    end

    // 3. backpressure at 0x3008 (reset mid-stream first)
    do_reset();
    bus.id_ready = 1'b1;
    repeat (3) cycle();
    check_eq("bp_head", bus.id_pc, 32'h0000_3008);
    bus.id_ready = 1'b0;
    repeat (5) cycle();
    check_eq("bp_hold", bus.id_pc, 32'h0000_3008);
`ifdef IF_FIFO_EN
    check_eq("bp_addr", bus.im_addr, 32'h0000_3010);
`else
    check_eq("bp_addr", bus.im_addr, 32'h0000_300C);
`endif
    bus.id_ready = 1'b1;
    cycle();
    check_eq("bp_next", bus.id_pc, 32'h0000_300C);
    repeat (5) cycle();

    // 4. redirect while decode stalled
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3403;
    cycle();
    check_eq("rd_addr", bus.im_addr, 32'h0000_3400);
    bus.redirect_valid = 1'b0;
    cycle();
    check_eq("rd_pc", bus.id_pc, 32'h0000_3400);

    // 5. address wrap
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    check_eq("wrap_hi", bus.id_pc, 32'hFFFF_FFFC);
    cycle();
    check_eq("wrap_lo", bus.id_pc, 32'h0000_0000);

    // 6. async reset during a stall, between clock edges
    bus.id_ready = 1'b0;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("arst_addr", bus.im_addr, 32'h0000_3000);
    check_eq("arst_pc", bus.id_pc, 32'd0);
    rst_n        = 1'b1;
    exp_pc       = RESET_PC;
    bus.id_ready = 1'b1;
    cycle();
    check_eq("arst_restart", bus.id_pc, 32'h0000_3000);

    // random ready / redirect traffic
    for (int n = 0; n < 400; n++) begin
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
